// File: rtl/hcsr04_pkg.sv
// Shared constants and types for the HC-SR04 scan controller and related schedulers.
// State encoding, 50 MHz timing defaults and the timeout length code live here.
package hcsr04_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // 60 ms gap and 50 ms timeout at a 50 MHz clock
    localparam int GAP_CYC_60MS = 3000000;
    localparam int TMO_CYC_50MS = 2500000;

    localparam logic [31:0] LEN_TMO_CODE = 32'hFFFF_FFFF;

endpackage

// File: rtl/hcsr04_scan_ctrl_if.sv
// Bundle between the scan controller, the HC-SR04 drivers and the result consumer.
// The controller uses the master modport; the environment around it uses slave.
interface hcsr04_scan_ctrl_if
    import hcsr04_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CH_W    = 2,
    parameter int CAP_LEN = 16
);
    // drv_en[i] stays high until driver i pulls drv_done[i] low (accept), then the
    // measurement ends when drv_done[i] returns high. res_valid is a one-cycle strobe
    // with no backpressure; res_ch/res_len/res_tmo hold until the next strobe.
    logic                      run;
    logic [N_CH-1:0]           mask;
    logic [N_CH-1:0]           drv_done;
    logic [N_CH*CAP_LEN-1:0]   drv_len;
    logic [N_CH-1:0]           drv_en;
    logic                      res_valid;
    logic [CH_W-1:0]           res_ch;
    logic [CAP_LEN-1:0]        res_len;
    logic                      res_tmo;
    logic                      busy;
    state_e                    dbg_state;

    modport master (
        input  run, mask, drv_done, drv_len,
        output drv_en, res_valid, res_ch, res_len, res_tmo, busy, dbg_state
    );

    modport slave (
        output run, mask, drv_done, drv_len,
        input  drv_en, res_valid, res_ch, res_len, res_tmo, busy, dbg_state
    );

endinterface

// File: rtl/hcsr04_scan_ctrl_rr_pick.sv
// Masked round-robin finder: first set mask bit strictly after cur, wrapping around.
// Falls back to cur itself when it is the only set bit.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] cur,
    output logic [W-1:0] nxt,
    output logic         any
);

    logic found;
    int   idx;

    always_comb begin
        nxt   = cur;
        found = 1'b0;
        idx   = 0;
        // offset N lands back on cur, covering the single-channel case
        for (int k = 1; k <= N; k++) begin
            idx = (int'(cur) + k) % N;
            if (!found && mask[idx]) begin
                nxt   = W'(idx);
                found = 1'b1;
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/hcsr04_scan_ctrl.sv
// Round-robin HC-SR04 scan scheduler: fires one sensor at a time, enforces an
// inter-ping gap, bounds each measurement with a timeout and emits tagged results.
module hcsr04_scan_ctrl
    import hcsr04_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CH_W    = 2,
    parameter int CAP_LEN = 16,
    parameter int TMR_W   = 22,
    parameter int GAP_CYC = GAP_CYC_60MS,
    parameter int TMO_CYC = TMO_CYC_50MS
) (
    input  logic                clk50M,
    input  logic                rst,
    hcsr04_scan_ctrl_if.master  bus
);

    localparam logic [CAP_LEN-1:0] LEN_TMO  = LEN_TMO_CODE[CAP_LEN-1:0];
    localparam logic [TMR_W-1:0]   TMO_LOAD = TMR_W'(TMO_CYC);
    localparam logic [TMR_W-1:0]   GAP_LOAD = TMR_W'(GAP_CYC);

    state_e               state_q, state_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [N_CH-1:0]      drv_en_q, drv_en_d;
    logic                 res_valid_q, res_valid_d;
    logic [CH_W-1:0]      res_ch_q, res_ch_d;
    logic [CAP_LEN-1:0]   res_len_q, res_len_d;
    logic                 res_tmo_q, res_tmo_d;

    logic [CH_W-1:0]      pick_nxt;
    logic                 pick_any;
    logic                 start_ok;
    logic                 done_cur;
    logic [CAP_LEN-1:0]   len_cur;
    logic [TMR_W-1:0]     timer_dec;
    logic                 tmo_fire;

    function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] i);
        logic [N_CH-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    rr_pick #(
        .N (N_CH),
        .W (CH_W)
    ) u_pick (
        .mask (bus.mask),
        .cur  (ch_q),
        .nxt  (pick_nxt),
        .any  (pick_any)
    );

    assign start_ok  = bus.run && pick_any;
    assign done_cur  = bus.drv_done[ch_q];
    assign len_cur   = bus.drv_len[int'(ch_q)*CAP_LEN +: CAP_LEN];
    assign timer_dec = (timer_q != '0) ? timer_q - TMR_W'(1) : '0;

    always_ff @(posedge clk50M) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ch_q        <= CH_W'(N_CH - 1);
            timer_q     <= '0;
            drv_en_q    <= '0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_len_q   <= '0;
            res_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            timer_q     <= timer_d;
            drv_en_q    <= drv_en_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_len_q   <= res_len_d;
            res_tmo_q   <= res_tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        timer_d     = timer_q;
        drv_en_d    = drv_en_q;
        res_valid_d = 1'b0;
        res_ch_d    = res_ch_q;
        res_len_d   = res_len_q;
        res_tmo_d   = res_tmo_q;
        tmo_fire    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d  = ST_ARM;
                    ch_d     = pick_nxt;
                    timer_d  = TMO_LOAD;
                    drv_en_d = onehot(pick_nxt);
                end
            end
            ST_ARM: begin
                // timer keeps running into MEAS so one budget covers arm + measure
                timer_d = timer_dec;
                if (!done_cur) begin
                    drv_en_d = '0;
                    state_d  = ST_MEAS;
                end else if (timer_q == '0) begin
                    tmo_fire = 1'b1;
                end
            end
            ST_MEAS: begin
                timer_d = timer_dec;
                if (done_cur) begin
                    res_valid_d = 1'b1;
                    res_ch_d    = ch_q;
                    res_len_d   = len_cur;
                    res_tmo_d   = 1'b0;
                    timer_d     = GAP_LOAD;
                    state_d     = ST_GAP;
                end else if (timer_q == '0) begin
                    tmo_fire = 1'b1;
                end
            end
            ST_GAP: begin
                timer_d = timer_dec;
                if (timer_q == '0) begin
                    if (start_ok) begin
                        state_d  = ST_ARM;
                        ch_d     = pick_nxt;
                        timer_d  = TMO_LOAD;
                        drv_en_d = onehot(pick_nxt);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tmo_fire) begin
            res_valid_d = 1'b1;
            res_ch_d    = ch_q;
            res_len_d   = LEN_TMO;
            res_tmo_d   = 1'b1;
            drv_en_d    = '0;
            timer_d     = GAP_LOAD;
            state_d     = ST_GAP;
        end
    end

    assign bus.drv_en    = drv_en_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_ch    = res_ch_q;
    assign bus.res_len   = res_len_q;
    assign bus.res_tmo   = res_tmo_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_hcsr04_scan_ctrl.sv
// Directed bench for hcsr04_scan_ctrl with N_CH=4, GAP_CYC=20, TMO_CYC=50 and
// behavioural HC-SR04 driver models on every channel.
module tb_hcsr04_scan_ctrl;
    import hcsr04_pkg::*;

    localparam int N_CH    = 4;
    localparam int CH_W    = 2;
    localparam int CAP_LEN = 16;

    logic clk50M = 1'b0;
    logic rst;
    int   cyc = 0;

    hcsr04_scan_ctrl_if #(.N_CH(N_CH), .CH_W(CH_W), .CAP_LEN(CAP_LEN)) bus ();

    hcsr04_scan_ctrl #(
        .N_CH    (N_CH),
        .CH_W    (CH_W),
        .CAP_LEN (CAP_LEN),
        .TMR_W   (22),
        .GAP_CYC (20),
        .TMO_CYC (50)
    ) dut (
        .clk50M (clk50M),
        .rst    (rst),
        .bus    (bus)
    );

    // clock / reset
    initial forever #10 clk50M = ~clk50M;
    always @(posedge clk50M) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_mis = 0;

    // driver model: done drops 2 cycles after enable, rises at rise_t (0 = never)
    int rise_t [N_CH] = '{12, 12, 12, 12};
    int t_cnt  [N_CH] = '{0, 0, 0, 0};
    bit ph     [N_CH] = '{0, 0, 0, 0};

    initial begin
        bus.drv_done = '1;
        for (int i = 0; i < N_CH; i++) bus.drv_len[i*CAP_LEN +: CAP_LEN] = 16'(i*100 + 7);
        forever begin
            @(negedge clk50M);
            for (int i = 0; i < N_CH; i++) begin
                if (!ph[i]) begin
                    if (bus.drv_en[i]) begin
                        ph[i]    = 1'b1;
                        t_cnt[i] = 1;
                    end
                end else begin
                    t_cnt[i] = t_cnt[i] + 1;
                    if (t_cnt[i] == 2) bus.drv_done[i] = 1'b0;
                    if (rise_t[i] != 0 && t_cnt[i] >= rise_t[i]) begin
                        bus.drv_done[i] = 1'b1;
                        ph[i]           = 1'b0;
                    end
                end
            end
        end
    end

    // enable monitor: rise times, spacing, per-channel counts, one-hot check
    int en_rise_cyc = 0;
    int last_rise   = -1;
    int min_gap     = 1000000;
    int en_total    = 0;
    int onehot_viol = 0;
    int en_cnt [N_CH] = '{0, 0, 0, 0};
    logic [N_CH-1:0] prev_en = '0;

    initial forever begin
        @(negedge clk50M);
        if ($countones(bus.drv_en) > 1) onehot_viol++;
        if (bus.drv_en != '0 && prev_en == '0) begin
            if (last_rise >= 0 && (cyc - last_rise) < min_gap) min_gap = cyc - last_rise;
            last_rise   = cyc;
            en_rise_cyc = cyc;
            en_total++;
            for (int i = 0; i < N_CH; i++) if (bus.drv_en[i]) en_cnt[i]++;
        end
        prev_en = bus.drv_en;
    end

    // scoreboard helpers
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int res_cyc = 0;

    task automatic wait_result(input string tag, input int max);
        int k;
        k = 0;
        do begin
            @(negedge clk50M);
            k++;
        end while (!bus.res_valid && k < max);
        res_cyc = cyc;
        chk({tag, "_seen"}, 32'(bus.res_valid), 32'd1);
    endtask

    task automatic wait_en(input string tag, input int ch, input int max);
        int k;
        k = 0;
        do begin
            @(negedge clk50M);
            k++;
        end while (!bus.drv_en[ch] && k < max);
        chk({tag, "_en_seen"}, 32'(bus.drv_en[ch]), 32'd1);
    endtask

    task automatic chk_result(input string tag, input int ch, input logic [15:0] len,
                              input logic tmo, input int lat);
        chk({tag, "_ch"},  32'(bus.res_ch),  32'(ch));
        chk({tag, "_len"}, 32'(bus.res_len), 32'(len));
        chk({tag, "_tmo"}, 32'(bus.res_tmo), 32'(tmo));
        chk({tag, "_lat"}, 32'(res_cyc - en_rise_cyc), 32'(lat));
    endtask

    int exp_ch [4];
    int base0, base2, base_tot;

    initial begin
        rst      = 1'b1;
        bus.run  = 1'b0;
        bus.mask = '0;
        repeat (2) @(negedge clk50M);

        // reset state
        chk("rst_drv_en",    32'(bus.drv_en),    32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_ch",    32'(bus.res_ch),    32'd0);
        chk("rst_res_len",   32'(bus.res_len),   32'd0);
        chk("rst_res_tmo",   32'(bus.res_tmo),   32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_state",     32'(bus.dbg_state), 32'(ST_IDLE));
        rst = 1'b0;

        // full mask round robin 0,1,2,3,0
        bus.mask = 4'b1111;
        bus.run  = 1'b1;
        wait_result("s1_r0", 200);
        chk_result("s1_r0", 0, 16'd7, 1'b0, 12);
        chk("s1_busy", 32'(bus.busy), 32'd1);
        @(negedge clk50M);
        chk("s1_pulse", 32'(bus.res_valid), 32'd0);
        chk("s1_hold",  32'(bus.res_len),   32'd7);
        for (int r = 1; r < 5; r++) begin
            wait_result("s1_rr", 200);
            chk_result("s1_rr", r % 4, 16'((r % 4)*100 + 7), 1'b0, 12);
        end
        chk("s1_en_spacing", 32'(min_gap), 32'd33);

        // mask 1010: channels 1 and 3 alternate
        bus.mask = 4'b1010;
        base0 = en_cnt[0];
        base2 = en_cnt[2];
        exp_ch = '{1, 3, 1, 3};
        for (int r = 0; r < 4; r++) begin
            wait_result("s2_rr", 200);
            chk_result("s2_rr", exp_ch[r], 16'(exp_ch[r]*100 + 7), 1'b0, 12);
        end
        chk("s2_no_en0", 32'(en_cnt[0]), 32'(base0));
        chk("s2_no_en2", 32'(en_cnt[2]), 32'(base2));

        // channel 2 hangs in measurement -> timeout, scan continues to ch3
        bus.mask  = 4'b1111;
        rise_t[2] = 0;
        wait_result("s3_c0", 200);
        chk_result("s3_c0", 0, 16'd7, 1'b0, 12);
        wait_result("s3_c1", 200);
        chk_result("s3_c1", 1, 16'd107, 1'b0, 12);
        wait_result("s3_c2", 200);
        chk_result("s3_c2", 2, 16'hFFFF, 1'b1, 51);
        rise_t[2] = 12;
        wait_result("s3_c3", 200);
        chk_result("s3_c3", 3, 16'd307, 1'b0, 12);

        // run dropped during ch1 measurement
        wait_result("s4_c0", 200);
        chk_result("s4_c0", 0, 16'd7, 1'b0, 12);
        wait_en("s4_c1", 1, 100);
        repeat (4) @(negedge clk50M);
        chk("s4_in_meas", 32'(bus.dbg_state), 32'(ST_MEAS));
        bus.run = 1'b0;
        wait_result("s4_c1", 100);
        chk_result("s4_c1", 1, 16'd107, 1'b0, 12);
        repeat (22) @(negedge clk50M);
        chk("s4_idle", 32'(bus.dbg_state), 32'(ST_IDLE));
        chk("s4_busy", 32'(bus.busy),      32'd0);
        base_tot = en_total;
        repeat (60) @(negedge clk50M);
        chk("s4_no_en", 32'(en_total), 32'(base_tot));

        // mask=0 with run=1 stays idle
        bus.mask = '0;
        bus.run  = 1'b1;
        repeat (10) @(negedge clk50M);
        chk("s5_m0_state",  32'(bus.dbg_state), 32'(ST_IDLE));
        chk("s5_m0_busy",   32'(bus.busy),      32'd0);
        chk("s5_m0_drv_en", 32'(bus.drv_en),    32'd0);

        // done rising exactly when the timer reaches zero: done wins
        rise_t[2] = 51;
        bus.mask  = 4'b0100;
        wait_en("s5_c2", 2, 50);
        wait_result("s5_c2", 100);
        chk_result("s5_c2", 2, 16'd207, 1'b0, 51);
        rise_t[2] = 12;

        // reset mid-GAP
        repeat (5) @(negedge clk50M);
        chk("s6_in_gap", 32'(bus.dbg_state), 32'(ST_GAP));
        bus.mask = 4'b1111;
        rst = 1'b1;
        @(negedge clk50M);
        chk("s6g_drv_en",    32'(bus.drv_en),    32'd0);
        chk("s6g_res_valid", 32'(bus.res_valid), 32'd0);
        chk("s6g_res_ch",    32'(bus.res_ch),    32'd0);
        chk("s6g_res_len",   32'(bus.res_len),   32'd0);
        chk("s6g_res_tmo",   32'(bus.res_tmo),   32'd0);
        chk("s6g_busy",      32'(bus.busy),      32'd0);
        chk("s6g_state",     32'(bus.dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        wait_en("s6g_first", 0, 40);
        chk("s6g_first_pick", 32'(bus.drv_en),    32'h1);
        chk("s6g_arm",        32'(bus.dbg_state), 32'(ST_ARM));

        // reset mid-ARM
        rst = 1'b1;
        @(negedge clk50M);
        chk("s6a_drv_en", 32'(bus.drv_en),    32'd0);
        chk("s6a_busy",   32'(bus.busy),      32'd0);
        chk("s6a_state",  32'(bus.dbg_state), 32'(ST_IDLE));
        repeat (15) @(negedge clk50M);
        rst = 1'b0;
        wait_en("s6a_first", 0, 40);
        chk("s6a_first_pick", 32'(bus.drv_en), 32'h1);
        wait_result("s6a_c0", 100);
        chk_result("s6a_c0", 0, 16'd7, 1'b0, 12);

        chk("onehot_drv_en", 32'(onehot_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
